// File: rtl/alu_seq_ctrl.sv
// Byte-serial multi-precision ALU sequencer: streams NUM_BYTES operand pairs LSB first and chains carry/borrow.
// Optional abort input is enabled by defining ALU_SEQ_ABORT_EN.
//   state | meaning
//   IDLE  | waiting for start_i; flags hold the last operation's outcome
//   RUN   | accepting operand byte pairs, one ALU step per handshake
//   DRAIN | last result byte waiting to be accepted, then done_o
module alu_seq_ctrl #(
  parameter int NUM_BYTES     = 4,
  parameter int CONTROL_WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [CONTROL_WIDTH-1:0] op_i,
  input  logic [7:0]               a_byte_i,
  input  logic [7:0]               b_byte_i,
  input  logic                     byte_valid_i,
  output logic                     byte_ready_o,
  output logic [7:0]               result_byte_o,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     carry_borrow_o,
  output logic [1:0]               status_flag_o
`ifdef ALU_SEQ_ABORT_EN
  ,
  input  logic                     abort_i
`endif
);

  localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A         = CONTROL_WIDTH'(0);
  localparam logic [CONTROL_WIDTH-1:0] OUTPUT_B         = CONTROL_WIDTH'(1);
  localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_PLUS_B  = CONTROL_WIDTH'(2);
  localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_MINUS_B = CONTROL_WIDTH'(3);
  localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_AND_B   = CONTROL_WIDTH'(4);
  localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_OR_B    = CONTROL_WIDTH'(5);
  localparam logic [CONTROL_WIDTH-1:0] OUTPUT_A_XOR_B   = CONTROL_WIDTH'(6);
  localparam logic [CONTROL_WIDTH-1:0] OUTPUT_NOT_A     = CONTROL_WIDTH'(7);

  localparam logic [1:0] DEFAULT_FLAG  = 2'd0;
  localparam logic [1:0] ZERO_FLAG     = 2'd1;
  localparam logic [1:0] NEGATIVE_FLAG = 2'd2;
  localparam logic [1:0] OVERFLOW_FLAG = 2'd3;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [CONTROL_WIDTH-1:0] op_q;
  logic                     carry_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     zero_q;
  logic [7:0]               result_q;
  logic                     rvalid_q;
  logic                     done_q;
  logic                     cb_q;
  logic [1:0]               flag_q;

  logic       abort_act;
  logic       hs_in, hs_out, last_byte;
  logic       do_start, load_byte, finish, abort_hit;
  logic [8:0] sum9, diff9;
  logic [7:0] alu_res;
  logic       alu_cout;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_act = abort_i;
`else
  assign abort_act = 1'b0;
`endif

  assign byte_ready_o   = (state_q == RUN) && (!rvalid_q || result_ready_i);
  assign hs_in          = byte_valid_i && byte_ready_o;
  assign hs_out         = rvalid_q && result_ready_i;
  assign last_byte      = (cnt_q == CNT_W'(NUM_BYTES - 1));
  assign result_byte_o  = result_q;
  assign result_valid_o = rvalid_q;
  assign busy_o         = (state_q == RUN) || (state_q == DRAIN);
  assign done_o         = done_q;
  assign carry_borrow_o = cb_q;
  assign status_flag_o  = flag_q;

  // The carry register is cleared at start, so byte 0 naturally sees carry-in 0.
  assign sum9  = {1'b0, a_byte_i} + {1'b0, b_byte_i} + {8'd0, carry_q};
  assign diff9 = {1'b0, a_byte_i} - {1'b0, b_byte_i} - {8'd0, carry_q};

  always_comb begin
    alu_res  = 8'h00;
    alu_cout = 1'b0;
    case (op_q)
      OUTPUT_A:         alu_res = a_byte_i;
      OUTPUT_B:         alu_res = b_byte_i;
      OUTPUT_A_PLUS_B:  begin alu_res = sum9[7:0];  alu_cout = sum9[8];  end
      OUTPUT_A_MINUS_B: begin alu_res = diff9[7:0]; alu_cout = diff9[8]; end
      OUTPUT_A_AND_B:   alu_res = a_byte_i & b_byte_i;
      OUTPUT_A_OR_B:    alu_res = a_byte_i | b_byte_i;
      OUTPUT_A_XOR_B:   alu_res = a_byte_i ^ b_byte_i;
      OUTPUT_NOT_A:     alu_res = ~a_byte_i;
      default:          alu_res = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    load_byte = 1'b0;
    finish    = 1'b0;
    abort_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          do_start = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort_act) begin
          abort_hit = 1'b1;
          state_d   = IDLE;
        end else if (hs_in) begin
          load_byte = 1'b1;
          if (last_byte) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_act) begin
          abort_hit = 1'b1;
          state_d   = IDLE;
        end else if (hs_out) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      zero_q   <= 1'b1;
      result_q <= 8'h00;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      cb_q     <= 1'b0;
      flag_q   <= DEFAULT_FLAG;
    end else begin
      done_q <= 1'b0;
      if (do_start) begin
        op_q    <= op_i;
        carry_q <= 1'b0;
        cnt_q   <= '0;
        zero_q  <= 1'b1;
        cb_q    <= 1'b0;
        flag_q  <= DEFAULT_FLAG;
      end
      if (abort_hit) begin
        rvalid_q <= 1'b0;
        cb_q     <= 1'b0;
        flag_q   <= DEFAULT_FLAG;
      end else begin
        if (load_byte) begin
          result_q <= alu_res;
          rvalid_q <= 1'b1;
          carry_q  <= ((op_q == OUTPUT_A_PLUS_B) || (op_q == OUTPUT_A_MINUS_B)) ? alu_cout : 1'b0;
          zero_q   <= zero_q && (alu_res == 8'h00);
          cnt_q    <= cnt_q + CNT_W'(1);
        end else if (hs_out) begin
          rvalid_q <= 1'b0;
        end
        if (finish) begin
          cb_q   <= carry_q;
          done_q <= 1'b1;
          if ((op_q == OUTPUT_A_PLUS_B) && carry_q)       flag_q <= OVERFLOW_FLAG;
          else if ((op_q == OUTPUT_A_MINUS_B) && carry_q) flag_q <= NEGATIVE_FLAG;
          else if (zero_q)                                flag_q <= ZERO_FLAG;
          else                                            flag_q <= DEFAULT_FLAG;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: driver queues expected result bytes, a monitor checks them on each output handshake.
module tb_alu_seq_ctrl;
  localparam int NB = 4;
  localparam logic [2:0] OP_ADD = 3'd2, OP_SUB = 3'd3, OP_AND = 3'd4, OP_XOR = 3'd6;
  localparam logic [1:0] F_DEF = 2'd0, F_ZERO = 2'd1, F_NEG = 2'd2, F_OVF = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] a_byte = 8'h00, b_byte = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic [7:0] result_byte;
  logic       result_valid;
  logic       result_ready = 1'b1;
  logic       busy, done, carry_borrow;
  logic [1:0] status_flag;
`ifdef ALU_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int cyc = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_ctrl #(.NUM_BYTES(NB), .CONTROL_WIDTH(3)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .a_byte_i(a_byte), .b_byte_i(b_byte), .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready), .result_byte_o(result_byte),
    .result_valid_o(result_valid), .result_ready_i(result_ready),
    .busy_o(busy), .done_o(done), .carry_borrow_o(carry_borrow),
    .status_flag_o(status_flag)
`ifdef ALU_SEQ_ABORT_EN
    , .abort_i(abort)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 0);
    check({tag, "_result_valid"}, {31'd0, result_valid}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_carry"}, {31'd0, carry_borrow}, 0);
    check({tag, "_result_byte"}, {24'd0, result_byte}, 0);
    check({tag, "_flag"}, {30'd0, status_flag}, {30'd0, F_DEF});
  endtask

  // Monitor: pops one expected byte per output handshake and checks stability while stalled.
  initial begin : monitor
    logic       stalled;
    logic [7:0] held;
    logic [7:0] exp;
    stalled = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (result_valid) begin
          if (stalled) check("stall_hold", {24'd0, result_byte}, {24'd0, held});
          if (result_ready) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL unexpected_result: got %0h expected none", result_byte);
            end else begin
              exp = sb.pop_front();
              checks--;
              check("result_byte", {24'd0, result_byte}, {24'd0, exp});
            end
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held = result_byte;
          end
        end else begin
          stalled = 1'b0;
        end
        if (done) done_cnt++;
      end
    end
  end

  // Presents n byte pairs; optionally stalls the consumer 3 cycles before byte stall_before.
  task automatic send_bytes(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                            input int n, input int stall_before);
    int g;
    for (int i = 0; i < n; i++) begin
      sb.push_back(exp_res[8*i +: 8]);
      a_byte = a[8*i +: 8];
      b_byte = b[8*i +: 8];
      byte_valid = 1'b1;
      if (i == stall_before) begin
        result_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("byte_ready_stall", {31'd0, byte_ready}, 0);
          @(posedge clk); #1;
        end
        result_ready = 1'b1;
      end
      g = 0;
      @(negedge clk);
      while (!byte_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (!byte_ready) begin
        errors++; checks++;
        $display("FAIL byte_ready_timeout: got 0 expected 1");
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_cb,
                        input logic [1:0] exp_flag, input int stall_before, input logic hold_start);
    int c0, g, d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    op = opc;
    @(posedge clk); #1;
    c0 = cyc;
    if (hold_start) op = OP_SUB;
    else start = 1'b0;
    check({name, "_busy_run"}, {31'd0, busy}, 1);
    send_bytes(a, b, exp_res, NB, stall_before);
    start = 1'b0;
    g = 0;
    @(negedge clk);
    while (!done && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL %s_done_timeout: got 0 expected 1", name);
    end else begin
      if (stall_before < 0) check({name, "_latency"}, cyc - c0, NB + 1);
      check({name, "_carry"}, {31'd0, carry_borrow}, {31'd0, exp_cb});
      check({name, "_flag"}, {30'd0, status_flag}, {30'd0, exp_flag});
      check({name, "_busy_done"}, {31'd0, busy}, 0);
      check({name, "_sb_empty"}, sb.size(), 0);
      @(negedge clk);
      check({name, "_done_pulse"}, {31'd0, done}, 0);
      check({name, "_done_count"}, done_cnt - d0, 1);
    end
  endtask

  initial begin : driver
    int d0;
    #1 rst = 1'b1;
    #2 check_reset_vals("reset0");
    @(posedge clk); #1 rst = 1'b0;

    run_op("add_ffff", OP_ADD, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, F_DEF, -1, 1'b0);
    run_op("add_ovf",  OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, F_OVF, -1, 1'b0);
    run_op("sub_neg",  OP_SUB, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b1, F_NEG, -1, 1'b0);
    run_op("sub_zero", OP_SUB, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, F_ZERO, -1, 1'b0);
    run_op("bp_add",   OP_ADD, 32'h01FF80FF, 32'h00018001, 32'h02010100, 1'b0, F_DEF, 2, 1'b0);
    run_op("xor",      OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, F_DEF, -1, 1'b0);
    run_op("and_zero", OP_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0, F_ZERO, -1, 1'b0);

    // Reset in the middle of an operation after two of four bytes.
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; op = OP_ADD;
    @(posedge clk); #1;
    start = 1'b0;
    send_bytes(32'h11111111, 32'h22222222, 32'h33333333, 2, -1);
    #2 rst = 1'b1;
    #1 check_reset_vals("reset_mid");
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("reset_no_done", done_cnt - d0, 0);
    run_op("add_after_rst", OP_ADD, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, F_DEF, -1, 1'b0);

    run_op("start_held", OP_ADD, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, F_DEF, -1, 1'b1);

`ifdef ALU_SEQ_ABORT_EN
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; op = OP_ADD;
    @(posedge clk); #1;
    start = 1'b0;
    send_bytes(32'h000000FF, 32'h00000001, 32'h00000000, 1, -1);
    a_byte = 8'h00; b_byte = 8'h00; byte_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; byte_valid = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_rvalid", {31'd0, result_valid}, 0);
    check("abort_flag", {30'd0, status_flag}, {30'd0, F_DEF});
    check("abort_carry", {31'd0, carry_borrow}, 0);
    sb.delete();
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_op("add_after_abort", OP_ADD, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, F_DEF, -1, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Byte-serial multi-precision arithmetic controller that sequences a single `eight_bit_alu` over `NUM_BYTES` operand byte pairs, chaining carry/borrow between cycles in a register. It sits between the 8-bit I/O pins and the ALU datapath. Operand bytes stream in LSB first through a valid/ready handshake, result bytes stream out through a second handshake, and an aggregated status flag is reported for the full-width operation.

## Interface
- `NUM_BYTES`, default 4: operand width in bytes; legal range 2..8.
- `clk_i`  in  1  system clock; all state updates on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  starts an operation; sampled only in IDLE.
- `op_i`  in  `CONTROL_WIDTH`  ALU function code; latched on an accepted start.
- `a_byte_i`  in  8  operand A byte.
- `b_byte_i`  in  8  operand B byte.
- `byte_valid_i`  in  1  operand byte pair valid.
- `byte_ready_o`  out  1  controller accepts the operand byte pair.
- `result_byte_o`  out  8  result byte.
- `result_valid_o`  out  1  `result_byte_o` valid.
- `result_ready_i`  in  1  consumer accepts the result byte.
- `busy_o`  out  1  high in RUN and DRAIN.
- `done_o`  out  1  one-cycle pulse when the operation completes.
- `carry_borrow_o`  out  1  final carry/borrow; held until the next start.
- `status_flag_o`  out  2  aggregated flag; held until the next start.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - `start_i` = 1 → latch `op_i`, clear the carry register, byte counter, and all-zero tracker (tracker set to 1), then go to RUN.
  - On the same edge, clear `carry_borrow_o` and set `status_flag_o` to `DEFAULT_FLAG`.
- RUN:
  - Operand handshake: `byte_valid_i && byte_ready_o`.
  - Each handshake drives the ALU with the byte pair, the latched op, and carry-in taken from the carry register.
  - Byte 0 uses carry-in 0.
  - The ALU result loads into the output register; the ALU carry/borrow-out loads into the carry register.
  - Zero tracker: ANDed with (result == 0).
  - Counter increments. On the handshake with counter == `NUM_BYTES`-1, go to DRAIN.
- DRAIN: when the last result byte is accepted (`result_valid_o && result_ready_i`):
  - `carry_borrow_o` takes the carry register.
  - `status_flag_o` is set by priority:
    - op = `OUTPUT_A_PLUS_B` and carry = 1 → `OVERFLOW_FLAG`.
    - op = `OUTPUT_A_MINUS_B` and carry = 1 → `NEGATIVE_FLAG`.
    - Otherwise, all result bytes zero → `ZERO_FLAG`.
    - Otherwise → `DEFAULT_FLAG`.
  - `done_o` pulses; go to IDLE.
- Non-arithmetic ops: the ALU carry-out is ignored and the carry register stays 0.
- `start_i` outside IDLE is ignored.
- Operand bytes presented in IDLE or DRAIN are not accepted (`byte_ready_o` = 0).
- Asynchronous reset in any state:
  - Return to IDLE.
  - Any partial result is discarded.
  - No `done_o` pulse is generated.

## Timing
- Reset values:
  - `byte_ready_o`, `result_valid_o`, `busy_o`, `done_o`, `carry_borrow_o` = 0.
  - `result_byte_o` = 0x00.
  - `status_flag_o` = `DEFAULT_FLAG`.
- `byte_ready_o` = RUN && (!`result_valid_o` || `result_ready_i`). It is combinational, so an operand byte can be accepted in the same cycle as a result byte.
- Latency: a result byte is valid on the cycle after its operand handshake.
- Throughput: one byte per cycle under no backpressure. Minimum operation length is `NUM_BYTES`+1 cycles from the start edge to `done_o`.
- `result_byte_o` is stable while `result_valid_o` && !`result_ready_i`.
- `result_valid_o` clears on acceptance unless a new byte loads on the same edge.
- `done_o` asserts on the cycle after the final result handshake, together with the updated flags; `busy_o` is low in that cycle.
- A new start is accepted on the `done_o` cycle at the earliest.

## Configuration
- `ALU_SEQ_ABORT_EN` defined:
  - Adds input port `abort_i` (1 bit).
  - `abort_i` = 1 in RUN or DRAIN → next state IDLE and `result_valid_o` cleared.
  - `carry_borrow_o` = 0 and `status_flag_o` = `DEFAULT_FLAG`; no `done_o` pulse.
  - `abort_i` takes priority over an operand handshake in the same cycle.
- Macro undefined: the port is absent, and an operation always runs to completion or reset.

## Test plan
- `NUM_BYTES`=4, add 0x0000FFFF + 0x00000001 → result bytes 00,00,01,00; `carry_borrow_o`=0; `DEFAULT_FLAG`; `done_o` 5 cycles after start.
- Add 0xFFFFFFFF + 0x00000001 → bytes 00,00,00,00; `carry_borrow_o`=1; `OVERFLOW_FLAG` (takes priority over zero).
- Subtract 0x00000001 − 0x00000002 → bytes FF,FF,FF,FF; `carry_borrow_o`=1; `NEGATIVE_FLAG`. Subtract 0x12345678 − 0x12345678 → all 00; `ZERO_FLAG`.
- Backpressure:
  - Hold `result_ready_i`=0 for 3 cycles after byte 1 → `byte_ready_o`=0 and `result_byte_o` stable throughout.
  - After release, the remaining bytes are correct and the carry chain is preserved.
- Reset and ignored stimulus:
  - Assert `rst_i` after byte 2 of 4 → all outputs return to reset values immediately; no `done_o`.
  - A new add 0x00000003 + 0x00000004 afterwards returns 07,00,00,00.
  - `start_i` held high during RUN has no effect.
- With `ALU_SEQ_ABORT_EN`: `abort_i` on byte 1 → IDLE next cycle, `result_valid_o`=0, `DEFAULT_FLAG`, no `done_o`.
